pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_skid_slot.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 175 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: held-data state
// encoding and the default channel widths / bubble instruction.
package pipe_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // EMPTY: nothing held; ONE: main entry valid; TWO: main plus skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single valid+data holding register with load and clear.
// On clear the bits selected by CLR_MASK take CLR_VAL and the rest keep
// their value, so the main entry can show a bubble instruction while
// keeping its last program counter.
module pipe_skid_slot #(
    parameter int              DW       = 64,
    parameter logic [DW-1:0]   RST_VAL  = '0,
    parameter logic [DW-1:0]   CLR_MASK = '0,
    parameter logic [DW-1:0]   CLR_VAL  = '0
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Slot storage: clear wins over load so a kill can never be overridden.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= (data_q & ~CLR_MASK) | (CLR_VAL & CLR_MASK);
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// One-deep pipeline register for a pc/instruction pair with valid/ready
// handshakes on both sides and a synchronous flush.
// Build option: PIPE_STAGE_SKID_EN adds a skid entry so that in_ready is a
// pure register output (no combinational path from out_ready). Without it
// in_ready = out_ready || !out_valid.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instr_out
);

    localparam int DW = PC_W + INSTR_W;

    // Main entry resets to pc=0 / bubble; clearing replaces only the
    // instruction field with the bubble, leaving pc_out as it was.
    localparam logic [DW-1:0] MAIN_RST_VAL  = {{PC_W{1'b0}}, NOP_INSTR};
    localparam logic [DW-1:0] MAIN_CLR_MASK = {{PC_W{1'b0}}, {INSTR_W{1'b1}}};
    localparam logic [DW-1:0] MAIN_CLR_VAL  = {{PC_W{1'b0}}, NOP_INSTR};

    pipe_state_e   state_q;
    pipe_state_e   state_d;
    logic          in_xfer_s;
    logic          out_xfer_s;
    logic          main_load_s;
    logic          main_clear_s;
    logic          main_valid_s;
    logic [DW-1:0] main_din_s;
    logic [DW-1:0] main_data_s;
`ifdef PIPE_STAGE_SKID_EN
    logic          skid_load_s;
    logic          skid_clear_s;
    logic          main_from_skid_s;
    logic          skid_valid_s;
    logic [DW-1:0] skid_data_s;
`endif

    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid && out_ready;

    // Next-state and slot control; flush overrides every other event.
    always_comb begin
        state_d          = state_q;
        main_load_s      = 1'b0;
        main_clear_s     = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
`endif
        if (flush) begin
            state_d      = ST_EMPTY;
            main_clear_s = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clear_s = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        main_load_s = 1'b1;
                        state_d     = ST_ONE;
                    end else begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        // New pair replaces the one leaving this edge.
                        main_load_s = 1'b1;
                        state_d     = ST_ONE;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (in_xfer_s) begin
                        // Downstream stalled: park the new pair in the skid.
                        skid_load_s = 1'b1;
                        state_d     = ST_TWO;
                    end
`endif
                    else if (out_xfer_s) begin
                        main_clear_s = 1'b1;
                        state_d      = ST_EMPTY;
                    end else begin
                        state_d      = ST_ONE;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_TWO: begin
                    if (out_xfer_s) begin
                        // Skid moves into main; no input accepted in TWO.
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clear_s     = 1'b1;
                        state_d          = ST_ONE;
                    end else begin
                        state_d          = ST_TWO;
                    end
                end
`endif
                default: begin
                    state_d      = ST_EMPTY;
                    main_clear_s = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    skid_clear_s = 1'b1;
`endif
                end
            endcase
        end
    end

    // Held-data state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    assign main_din_s = main_from_skid_s ? skid_data_s : {pc_in, instr_in};

    pipe_skid_slot #(
        .DW       (DW),
        .RST_VAL  ({DW{1'b0}}),
        .CLR_MASK ({DW{1'b0}}),
        .CLR_VAL  ({DW{1'b0}})
    ) u_skid (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .data_i  ({pc_in, instr_in}),
        .valid_o (skid_valid_s),
        .data_o  (skid_data_s)
    );

    assign in_ready = ~skid_valid_s;
`else
    assign main_din_s = {pc_in, instr_in};
    assign in_ready   = out_ready | ~main_valid_s;
`endif

    pipe_skid_slot #(
        .DW       (DW),
        .RST_VAL  (MAIN_RST_VAL),
        .CLR_MASK (MAIN_CLR_MASK),
        .CLR_VAL  (MAIN_CLR_VAL)
    ) u_main (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .load_i  (main_load_s),
        .clear_i (main_clear_s),
        .data_i  (main_din_s),
        .valid_o (main_valid_s),
        .data_o  (main_data_s)
    );

    assign out_valid           = main_valid_s;
    assign {pc_out, instr_out} = main_data_s;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: scenario tasks plus a scoreboard monitor
// that tracks every accepted pair and checks it on the output side.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pair_t;

    logic        CLK       = 1'b0;
    logic        RST_N     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] pc_in     = 32'h0;
    logic [31:0] instr_in  = 32'h0;
    logic        flush     = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    int    n_checks = 0;
    int    n_fail   = 0;
    pair_t sb_q[$];

    pipe_stage_reg #(
        .PC_W      (32),
        .INSTR_W   (32),
        .NOP_INSTR (NOP)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_out    (pc_out),
        .instr_out (instr_out)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    // Apply one cycle of inputs just after a rising edge; return just after
    // the next rising edge, which is the one that consumed them.
    task automatic drive(input logic iv, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        pc_in     = pc;
        instr_in  = mk_instr(pc);
        out_ready = ordy;
        flush     = fl;
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: reference occupancy model, handshake checks, output order.
    always @(negedge CLK) begin
        if (!RST_N) begin
            sb_q.delete();
        end else begin
`ifdef PIPE_STAGE_SKID_EN
            n_checks++;
            if (in_ready !== (sb_q.size() < 2))
                $display("FAIL sb_in_ready: got %b want %b", in_ready, sb_q.size() < 2);
`else
            n_checks++;
            if (in_ready !== (out_ready || sb_q.size() == 0))
                $display("FAIL sb_in_ready: got %b want %b", in_ready, out_ready || sb_q.size() == 0);
`endif
            if (in_ready !== ((sb_q.size() < 2) || 1'b0) && 1'b0) n_fail++;
            n_checks++;
            if (out_valid !== (sb_q.size() != 0)) begin
                n_fail++;
                $display("FAIL sb_out_valid: got %b want %b", out_valid, sb_q.size() != 0);
            end
            if (!out_valid) begin
                n_checks++;
                if (instr_out !== NOP) begin
                    n_fail++;
                    $display("FAIL sb_bubble: got %h want %h", instr_out, NOP);
                end
            end else if (sb_q.size() != 0) begin
                n_checks++;
                if ({pc_out, instr_out} !== sb_q[0]) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h/%h want %h/%h",
                             pc_out, instr_out, sb_q[0].pc, sb_q[0].instr);
                end
            end
            if (flush) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
                if (in_valid && in_ready) sb_q.push_back('{pc: pc_in, instr: instr_in});
            end
        end
    end

    // The in_ready comparison above needs its failure counted too.
    always @(negedge CLK) begin
        if (RST_N) begin
`ifdef PIPE_STAGE_SKID_EN
            if (in_ready !== (sb_q.size() < 2)) n_fail++;
`else
            if (in_ready !== (out_ready || sb_q.size() == 0)) n_fail++;
`endif
        end
    end

    task automatic test_reset();
        #1;
        n_checks++;
        if ({out_valid, pc_out, instr_out} !== {1'b0, 32'h0, NOP}) begin
            n_fail++;
            $display("FAIL reset_values: got %b/%h/%h want 0/0/%h", out_valid, pc_out, instr_out, NOP);
        end
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [4];
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pcs[i], 1'b1, 1'b0);
            n_checks++;
            if (out_valid !== 1'b1 || pc_out !== pcs[i]) begin
                n_fail++;
                $display("FAIL stream_%0d: got %b/%h want 1/%h", i, out_valid, pc_out, pcs[i]);
            end
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || instr_out !== NOP || pc_out !== 32'hC) begin
            n_fail++;
            $display("FAIL stream_drain: got %b/%h/%h want 0/%h/0000000c", out_valid, instr_out, pc_out, NOP);
        end
    endtask

    task automatic test_backpressure();
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || pc_out !== 32'h100) begin
            n_fail++;
            $display("FAIL bp_skid_full: got rdy=%b pc=%h want rdy=0 pc=00000100", in_ready, pc_out);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (pc_out !== 32'h100 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got %b/%h want 1/00000100", out_valid, pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (pc_out !== 32'h104 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: got %b/%h want 1/00000104", out_valid, pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
`else
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || pc_out !== 32'h200) begin
            n_fail++;
            $display("FAIL bp_stall: got rdy=%b pc=%h want rdy=0 pc=00000200", in_ready, pc_out);
        end
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        n_checks++;
        if (pc_out !== 32'h200 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got %b/%h want 1/00000200", out_valid, pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
`endif
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drained: got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h300, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 32'h304, 1'b0, 1'b0);
`endif
        drive(1'b1, 32'h308, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || instr_out !== NOP || pc_out !== 32'h300) begin
            n_fail++;
            $display("FAIL flush_kill: got %b/%h/%h want 0/%h/00000300", out_valid, instr_out, pc_out, NOP);
        end
        drive(1'b1, 32'h30C, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || pc_out !== 32'h300) begin
            n_fail++;
            $display("FAIL flush_drop: got %b/%h want 0/00000300", out_valid, pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: got %b want 0", out_valid);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        drive(1'b1, 32'h404, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'h404 || instr_out !== mk_instr(32'h404)) begin
            n_fail++;
            $display("FAIL simul_replace: got %b/%h/%h want 1/00000404/c0de0404", out_valid, pc_out, instr_out);
        end
`ifdef PIPE_STAGE_SKID_EN
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_state_one: got rdy=%b want 1", in_ready);
        end
`endif
        drive(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(i * 4),
                  1'($urandom_range(0, 2) != 0), 1'b0);
        end
        repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_lost: got %0d pairs outstanding want 0", sb_q.size());
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, pc_out, instr_out} !== {1'b0, 32'h0, NOP}) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%h/%h want 0/0/%h", out_valid, pc_out, instr_out, NOP);
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drive(1'b1, 32'h44, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'h44) begin
            n_fail++;
            $display("FAIL post_reset: got %b/%h want 1/00000044", out_valid, pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
